// File: rtl/ipd_controller_mac_pkg.sv
// Shared types for the I-PD controller: FSM states, multiplier operand selection
// and default parameter values.
package ipd_controller_mac_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CAPT  = 3'd1,
    ST_MUL_I = 3'd2,
    ST_MUL_P = 3'd3,
    ST_MUL_D = 3'd4,
    ST_SUM   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_I    = 2'd1,
    OP_P    = 2'd2,
    OP_D    = 2'd3
  } mul_op_t;

  localparam int DEF_W    = 19;
  localparam int DEF_FRAC = 8;
  localparam int DEF_DIV  = 250000;

  // The shared multiplier is time-multiplexed: each MUL_* state owns it for one clock.
  function automatic mul_op_t op_for_state(input state_t s);
    case (s)
      ST_MUL_I: op_for_state = OP_I;
      ST_MUL_P: op_for_state = OP_P;
      ST_MUL_D: op_for_state = OP_D;
      default:  op_for_state = OP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/ipd_controller_mac_fx_mul_sat.sv
// Signed fixed-point multiply: full 2W-bit product, arithmetic shift by FRAC,
// saturate back to W bits.
module ipd_controller_mac_fx_mul_sat #(
  parameter int W    = 19,
  parameter int FRAC = 8
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] p
);

  localparam logic signed [2*W-1:0] PMAX = {{(W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [2*W-1:0] PMIN = {{(W+1){1'b1}}, {(W-1){1'b0}}};

  logic signed [2*W-1:0] prod;
  logic signed [2*W-1:0] shifted;

  always_comb begin
    prod    = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
    // >>> on a signed value floors toward -inf
    shifted = prod >>> FRAC;
    if (shifted > PMAX) begin
      p = PMAX[W-1:0];
    end else if (shifted < PMIN) begin
      p = PMIN[W-1:0];
    end else begin
      p = shifted[W-1:0];
    end
  end

endmodule

// File: rtl/ipd_controller_mac.sv
// Discrete I-PD controller with sample divider, anti-windup clamping and one
// shared saturating multiplier sequenced by a six-state FSM.
module ipd_controller_mac
  import ipd_controller_mac_pkg::*;
#(
  parameter int W    = DEF_W,
  parameter int FRAC = DEF_FRAC,
  parameter int DIV  = DEF_DIV,
  parameter int UMAX = (2 ** (W - 1)) - 1,
  parameter int UMIN = -(2 ** (W - 1))
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic                Enable,
  input  logic signed [W-1:0] r,
  input  logic signed [W-1:0] y,
  input  logic signed [W-1:0] Kp,
  input  logic signed [W-1:0] Ki,
  input  logic signed [W-1:0] Kd,
  output logic signed [W-1:0] u,
  output logic                Listo,
  output logic                busy
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  localparam logic signed [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [W+1:0] UMAX_X  = (W+2)'(UMAX);
  localparam logic signed [W+1:0] UMIN_X  = (W+2)'(UMIN);

  // Difference of two W-bit values at W+1 bits, saturated back to W bits.
  function automatic logic signed [W-1:0] sat_diff(input logic signed [W-1:0] a,
                                                   input logic signed [W-1:0] b);
    logic signed [W:0] d;
    d = {a[W-1], a} - {b[W-1], b};
    if (d[W] != d[W-1]) begin
      sat_diff = d[W] ? SAT_MIN : SAT_MAX;
    end else begin
      sat_diff = d[W-1:0];
    end
  endfunction

  function automatic logic signed [W+1:0] ext(input logic signed [W-1:0] a);
    ext = {{2{a[W-1]}}, a};
  endfunction

  function automatic logic signed [W-1:0] clamp_x(input logic signed [W+1:0] v);
    if (v > UMAX_X) begin
      clamp_x = UMAX_X[W-1:0];
    end else if (v < UMIN_X) begin
      clamp_x = UMIN_X[W-1:0];
    end else begin
      clamp_x = v[W-1:0];
    end
  endfunction

  logic [CW-1:0] count_reg, count_next;
  logic          strobe;
  state_t        state_reg, state_next;

  logic signed [W-1:0] r_reg, y_reg, kp_reg, ki_reg, kd_reg;
  logic signed [W-1:0] e_reg, dy_reg;
  logic signed [W-1:0] i_reg, p_reg, d_reg, y_prev_reg;
  logic signed [W-1:0] u_reg;
  logic                listo_reg;

  logic signed [W-1:0] mul_a, mul_b, mul_p;
  mul_op_t             mul_op;

  // Sample divider: Enable=0 freezes the count but not a computation in flight.
  assign strobe = Enable && (count_reg == CNT_LAST);

  always_comb begin
    count_next = count_reg;
    if (Enable) begin
      count_next = strobe ? '0 : count_reg + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (strobe) state_next = ST_CAPT;
      ST_CAPT:  state_next = ST_MUL_I;
      ST_MUL_I: state_next = ST_MUL_P;
      ST_MUL_P: state_next = ST_MUL_D;
      ST_MUL_D: state_next = ST_SUM;
      ST_SUM:   state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    mul_op = op_for_state(state_reg);
    mul_a  = '0;
    mul_b  = '0;
    case (mul_op)
      OP_I: begin
        mul_a = ki_reg;
        mul_b = e_reg;
      end
      OP_P: begin
        mul_a = kp_reg;
        mul_b = y_reg;
      end
      OP_D: begin
        mul_a = kd_reg;
        mul_b = dy_reg;
      end
      default: begin
        mul_a = '0;
        mul_b = '0;
      end
    endcase
  end

  ipd_controller_mac_fx_mul_sat #(
    .W    (W),
    .FRAC (FRAC)
  ) u_fx_mul_sat (
    .a (mul_a),
    .b (mul_b),
    .p (mul_p)
  );

  // Datapath: a reset mid-sample drops the partial result along with I and y_prev.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_reg      <= '0;
      y_reg      <= '0;
      kp_reg     <= '0;
      ki_reg     <= '0;
      kd_reg     <= '0;
      e_reg      <= '0;
      dy_reg     <= '0;
      i_reg      <= '0;
      p_reg      <= '0;
      d_reg      <= '0;
      y_prev_reg <= '0;
      u_reg      <= '0;
      listo_reg  <= 1'b0;
    end else begin
      listo_reg <= (state_reg == ST_SUM);
      case (state_reg)
        ST_IDLE: begin
          if (strobe) begin
            r_reg  <= r;
            y_reg  <= y;
            kp_reg <= Kp;
            ki_reg <= Ki;
            kd_reg <= Kd;
          end
        end
        ST_CAPT: begin
          e_reg  <= sat_diff(r_reg, y_reg);
          dy_reg <= sat_diff(y_reg, y_prev_reg);
        end
        ST_MUL_I: i_reg <= clamp_x(ext(i_reg) + ext(mul_p));
        ST_MUL_P: p_reg <= mul_p;
        ST_MUL_D: begin
          d_reg      <= mul_p;
          y_prev_reg <= y_reg;
        end
        ST_SUM:  u_reg <= clamp_x(ext(i_reg) - ext(p_reg) - ext(d_reg));
        default: ;
      endcase
    end
  end

  assign u     = u_reg;
  assign Listo = listo_reg;
  assign busy  = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_ipd_controller_mac.sv
// Self-checking bench: two controllers (default clamps and +/-1000 clamps) share
// stimulus and are compared every clock against a behavioural sample-level model.
module tb_ipd_controller_mac;

  localparam int W     = 19;
  localparam int FRAC  = 8;
  localparam int DIV   = 16;
  localparam int CUMAX = 1000;
  localparam int CUMIN = -1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                Reset = 1'b1;
  logic                Enable = 1'b0;
  logic signed [W-1:0] r = '0, y = '0, Kp = '0, Ki = '0, Kd = '0;
  logic signed [W-1:0] u0, u1;
  logic                listo0, listo1, busy0, busy1;

  int checks = 0;
  int errors = 0;

  ipd_controller_mac #(.W(W), .FRAC(FRAC), .DIV(DIV)) dut (
    .CLK(clk), .Reset(Reset), .Enable(Enable), .r(r), .y(y), .Kp(Kp), .Ki(Ki), .Kd(Kd),
    .u(u0), .Listo(listo0), .busy(busy0)
  );

  ipd_controller_mac #(.W(W), .FRAC(FRAC), .DIV(DIV), .UMAX(CUMAX), .UMIN(CUMIN)) dut_c (
    .CLK(clk), .Reset(Reset), .Enable(Enable), .r(r), .y(y), .Kp(Kp), .Ki(Ki), .Kd(Kd),
    .u(u1), .Listo(listo1), .busy(busy1)
  );

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic longint clampv(input longint x, input longint lo, input longint hi);
    return (x > hi) ? hi : ((x < lo) ? lo : x);
  endfunction

  function automatic longint satw(input longint x);
    return clampv(x, -(64'sd1 <<< (W - 1)), (64'sd1 <<< (W - 1)) - 1);
  endfunction

  function automatic longint fx(input longint a, input longint b);
    return satw((a * b) >>> FRAC);
  endfunction

  longint lo_c[2];
  longint hi_c[2];
  longint m_i[2], m_u[2], pend_u[2];
  longint m_yprev;
  bit     m_listo, pend, model_ok;
  int     m_cnt, pend_edge, ecount;

  initial begin
    lo_c[0] = -(64'sd1 <<< (W - 1));
    hi_c[0] = (64'sd1 <<< (W - 1)) - 1;
    lo_c[1] = CUMIN;
    hi_c[1] = CUMAX;
    model_ok = 0;
    ecount = 0;
    pend = 0;
    forever begin
      @(posedge clk);
      ecount++;
      if (Reset) begin
        model_ok = 1;
        m_cnt = 0;
        m_yprev = 0;
        m_listo = 0;
        pend = 0;
        for (int k = 0; k < 2; k++) begin
          m_i[k] = 0;
          m_u[k] = 0;
        end
      end else if (model_ok) begin
        m_listo = 0;
        if (pend && pend_edge == ecount) begin
          m_u = pend_u;
          m_listo = 1;
          pend = 0;
        end
        if (Enable && m_cnt == DIV - 1 && !pend) begin
          longint e, dy, p, d, yl;
          yl = y;
          e  = satw(longint'(r) - yl);
          dy = satw(yl - m_yprev);
          p  = fx(Kp, yl);
          d  = fx(Kd, dy);
          for (int k = 0; k < 2; k++) begin
            m_i[k]    = clampv(m_i[k] + fx(Ki, e), lo_c[k], hi_c[k]);
            pend_u[k] = clampv(m_i[k] - p - d, lo_c[k], hi_c[k]);
          end
          m_yprev = yl;
          pend = 1;
          pend_edge = ecount + 5;
        end
        if (Enable) m_cnt = (m_cnt + 1) % DIV;
      end
    end
  end

  // Every-cycle comparison, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (model_ok) begin
        check("listo0", listo0, m_listo);
        check("listo1", listo1, m_listo);
        check("busy0", busy0, pend);
        check("busy1", busy1, pend);
        check("u0", u0, m_u[0]);
        check("u1", u1, m_u[1]);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic do_reset(input int cycles);
    @(negedge clk);
    Reset = 1'b1;
    repeat (cycles) @(negedge clk);
    Reset = 1'b0;
  endtask

  task automatic wait_listo(input string name, output longint v0, output longint v1,
                            output int edges);
    bit got;
    got = 0;
    edges = 0;
    v0 = 0;
    v1 = 0;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      edges++;
      if (listo0) begin
        got = 1;
        v0 = u0;
        v1 = u1;
      end
    end
    if (!got) check({name, "_timeout"}, 0, 1);
    $display("sample %s: u0=%0d u1=%0d after %0d clocks", name, v0, v1, edges);
  endtask

  task automatic set_in(input longint rr, input longint yy, input longint kp,
                        input longint ki, input longint kd);
    r  = W'(rr);
    y  = W'(yy);
    Kp = W'(kp);
    Ki = W'(ki);
    Kd = W'(kd);
  endtask

  longint v0, v1;
  int     edges, cnt;

  initial begin
    // 1: reset, divider timing
    set_in(0, 0, 0, 0, 0);
    Enable = 1'b1;
    do_reset(3);
    check("rst_u", u0, 0);
    check("rst_listo", listo0, 0);
    check("rst_busy", busy0, 0);
    wait_listo("t1a", v0, v1, edges);
    check("t1_first_latency", edges, DIV + 5);
    wait_listo("t1b", v0, v1, edges);
    check("t1_period", edges, DIV);
    @(negedge clk);
    check("t1_listo_width", listo0, 0);

    // 2: proportional only
    set_in(0, 512, 256, 0, 0);
    do_reset(3);
    for (int s = 0; s < 3; s++) begin
      wait_listo("t2", v0, v1, edges);
      check("t2_u0", v0, -512);
      check("t2_u1", v1, -512);
    end

    // 3: integral ramp
    set_in(1024, 0, 0, 64, 0);
    do_reset(3);
    for (int s = 1; s <= 4; s++) begin
      wait_listo("t3", v0, v1, edges);
      check("t3_u0", v0, 256 * s);
      check("t3_u1", v1, (256 * s > 1000) ? 1000 : 256 * s);
    end

    // 4: derivative kick on a step in y
    set_in(0, 0, 0, 0, 256);
    do_reset(3);
    wait_listo("t4", v0, v1, edges);
    check("t4_s1", v0, 0);
    y = W'(256);
    wait_listo("t4", v0, v1, edges);
    check("t4_s2", v0, -256);
    wait_listo("t4", v0, v1, edges);
    check("t4_s3", v0, 0);
    wait_listo("t4", v0, v1, edges);
    check("t4_s4", v0, 0);

    // 5: anti-windup on the clamped instance
    set_in(600, 0, 0, 256, 0);
    do_reset(3);
    wait_listo("t5", v0, v1, edges);
    check("t5_s1", v1, 600);
    wait_listo("t5", v0, v1, edges);
    check("t5_s2", v1, 1000);
    check("t5_s2_unclamped", v0, 1200);
    wait_listo("t5", v0, v1, edges);
    check("t5_s3", v1, 1000);
    r = -W'(600);
    wait_listo("t5", v0, v1, edges);
    check("t5_s4", v1, 400);
    wait_listo("t5", v0, v1, edges);
    check("t5_s5", v1, -200);

    // 6: reset during MUL_P discards the sample
    set_in(1024, 0, 0, 64, 0);
    do_reset(3);
    cnt = 0;
    while (!busy0 && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    check("t6_busy_seen", busy0, 1);
    repeat (2) @(negedge clk);
    Reset = 1'b1;
    @(negedge clk);
    Reset = 1'b0;
    check("t6_u", u0, 0);
    check("t6_busy", busy0, 0);
    wait_listo("t6", v0, v1, edges);
    check("t6_latency", edges, DIV + 5);
    check("t6_u_after", v0, 256);
    Enable = 1'b0;
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (listo0) cnt++;
    end
    check("t6_no_strobe", cnt, 0);
    Enable = 1'b1;
    wait_listo("t6", v0, v1, edges);
    check("t6_resume_latency", edges, DIV);
    check("t6_resume_u", v0, 512);

    // randomized phase
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 3) == 0)
          set_in($signed(W'($urandom)), $signed(W'($urandom)), $signed(W'($urandom)),
                 $signed(W'($urandom)), $signed(W'($urandom)));
        else
          set_in(longint'($urandom_range(0, 4095)) - 2048,
                 longint'($urandom_range(0, 4095)) - 2048,
                 longint'($urandom_range(0, 1023)) - 512,
                 longint'($urandom_range(0, 511)) - 256,
                 longint'($urandom_range(0, 1023)) - 512);
      end
      if ($urandom_range(0, 49) == 0) Enable = ($urandom_range(0, 3) != 0);
      Reset = ($urandom_range(0, 399) == 0);
    end
    Reset = 1'b0;
    Enable = 1'b1;
    repeat (40) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
